// File: rtl/dec_wb_arbiter.sv
// Writeback arbiter: per-source write FIFOs feeding the single GPR write port, plus a register
// reservation scoreboard for decode. Define WB_ARB_PERF_CNT_EN to add the conflict_cnt output.
module dec_wb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int RR_MODE    = 0
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      rsv_en,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic                      wen0,
    output logic [ADDR_W-1:0]         waddr0,
    output logic [DATA_W-1:0]         wd0,
    input  logic [ADDR_W-1:0]         rs1_addr,
    input  logic [ADDR_W-1:0]         rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy
`ifdef WB_ARB_PERF_CNT_EN
    ,
    output logic [15:0]               conflict_cnt
`endif
);

    localparam int IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_SRC - 1);

    logic [ADDR_W-1:0]   r_fifoAddr [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifoData [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wrPtr    [NUM_SRC];
    logic [PTR_W-1:0]    r_rdPtr    [NUM_SRC];
    logic [CNT_W-1:0]    r_count    [NUM_SRC];
    logic [IDX_W-1:0]    r_rrPtr;
    logic                r_wen0;
    logic [ADDR_W-1:0]   r_waddr0;
    logic [DATA_W-1:0]   r_wd0;
    logic [NUM_REGS-1:0] r_scoreboard;

    logic [NUM_SRC-1:0]  w_req;
    logic [NUM_SRC-1:0]  w_push;
    logic [NUM_SRC-1:0]  w_pop;
    logic                w_grantVld;
    logic [IDX_W-1:0]    w_grantIdx;
    logic [ADDR_W-1:0]   w_headAddr;
    logic [DATA_W-1:0]   w_headData;

    // Index reached by stepping 'offset' places past 'base', wrapping modulo NUM_SRC.
    function automatic logic [IDX_W-1:0] rrIndex(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return IDX_W'(sum);
    endfunction

    always_comb begin
        w_req     = '0;
        src_ready = '0;
        w_push    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_req[i]     = (r_count[i] != '0);
            src_ready[i] = !rst_l && (r_count[i] != FULL_CNT);
            w_push[i]    = src_valid[i] && src_ready[i];
        end
    end

    // Loops run from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_grantVld = |w_req;
        w_grantIdx = '0;
        if (RR_MODE == 0) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (w_req[i]) begin
                    w_grantIdx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUM_SRC; k >= 1; k--) begin
                if (w_req[rrIndex(r_rrPtr, k)]) begin
                    w_grantIdx = rrIndex(r_rrPtr, k);
                end
            end
        end
    end

    always_comb begin
        w_pop      = '0;
        w_headAddr = r_fifoAddr[w_grantIdx][r_rdPtr[w_grantIdx]];
        w_headData = r_fifoData[w_grantIdx][r_rdPtr[w_grantIdx]];
        for (int i = 0; i < NUM_SRC; i++) begin
            w_pop[i] = w_grantVld && (w_grantIdx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_push[i]) begin
                r_fifoAddr[i][r_wrPtr[i]] <= src_addr[i*ADDR_W +: ADDR_W];
                r_fifoData[i][r_wrPtr[i]] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_l) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_push[i]) begin
                    r_wrPtr[i] <= r_wrPtr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rdPtr[i] <= r_rdPtr[i] + PTR_W'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // A grant of register 0 still pops its entry and moves the pointer, but never writes.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            r_rrPtr  <= RR_RESET;
            r_wen0   <= 1'b0;
            r_waddr0 <= '0;
            r_wd0    <= '0;
        end else begin
            r_wen0 <= 1'b0;
            if (w_grantVld) begin
                if (RR_MODE != 0) begin
                    r_rrPtr <= w_grantIdx;
                end
                if (w_headAddr != '0) begin
                    r_wen0   <= 1'b1;
                    r_waddr0 <= w_headAddr;
                    r_wd0    <= w_headData;
                end
            end
        end
    end

    // The reservation is assigned last so a same-cycle set beats the commit clear.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            r_scoreboard <= '0;
        end else begin
            if (r_wen0) begin
                r_scoreboard[r_waddr0] <= 1'b0;
            end
            if (rsv_en && (rsv_addr != '0)) begin
                r_scoreboard[rsv_addr] <= 1'b1;
            end
        end
    end

    assign wen0     = r_wen0;
    assign waddr0   = r_waddr0;
    assign wd0      = r_wd0;
    assign rs1_busy = (rs1_addr != '0) && r_scoreboard[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && r_scoreboard[rs2_addr];

`ifdef WB_ARB_PERF_CNT_EN
    logic [15:0] r_conflictCnt;
    logic        w_multiReq;

    // Clearing the lowest set bit leaves something only when two or more sources wait.
    assign w_multiReq = |(w_req & (w_req - NUM_SRC'(1)));

    always_ff @(posedge clk) begin
        if (rst_l) begin
            r_conflictCnt <= '0;
        end else if (w_multiReq && (r_conflictCnt != 16'hFFFF)) begin
            r_conflictCnt <= r_conflictCnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflictCnt;
`endif

endmodule
